spi_target_mem: RTL and testbench

// - Downstream SPI target for the SPI stimulus master: decodes write-mem (0x02) and read-mem (0x0B) frames into a small word memory.
// - Returns read data on spi_sdo, so stimulus sequences can be closed-loop checked on the FPGA before the SoC is attached.
// - Same clock domain as the master (SCLK = clk_i/2), so edges are detected directly from clk_i with no synchronizer.

---
 rtl/spi_target_pkg.sv | 26 ++
 rtl/spi_target_ram.sv | 25 ++
 rtl/spi_target_mem.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_target_mem.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target memory: FSM states, opcodes and phase lengths.
package spi_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_e;

    localparam logic [7:0] OPC_WRITE = 8'h02;
    localparam logic [7:0] OPC_READ  = 8'h0B;

    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 32;
    localparam int DATA_BITS = 32;

    // Counter values seen on the final rise of each fixed-length phase.
    localparam logic [5:0] CMD_LAST  = 6'(CMD_BITS - 1);
    localparam logic [5:0] ADDR_LAST = 6'(ADDR_BITS - 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

endpackage

// File: rtl/spi_target_ram.sv
// Single-port word memory: synchronous write, asynchronous read.
module spi_target_ram
    import spi_target_pkg::*;
#(
    parameter int MEM_AW = 6
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [MEM_AW-1:0]    addr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    logic [DATA_BITS-1:0] mem_q [2**MEM_AW];

    // NOTE: the array has no reset so it maps onto RAM; committed words survive rst_i.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/spi_target_mem.sv
// SPI mode-0 target decoding write-mem (0x02) / read-mem (0x0B) frames into a word memory.
// Optional SPI_TARGET_WRCNT_EN adds a saturating count of committed writes on wr_count.
module spi_target_mem
    import spi_target_pkg::*;
#(
    parameter int MEM_AW       = 6,
    parameter int DUMMY_CYCLES = 34
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spi_sclk,
    input  logic        spi_sdi,
    input  logic        spi_cs,
    output logic        spi_sdo,
    output logic        frame_done,
    output logic [7:0]  last_cmd,
    output logic [31:0] last_addr,
    output logic [31:0] last_data,
    output logic        err
`ifdef SPI_TARGET_WRCNT_EN
    ,
    output logic [15:0] wr_count
`endif
);

    localparam logic [5:0] DUMMY_LAST = 6'(DUMMY_CYCLES - 1);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] sr_q, sr_d;
    logic        rd_q, rd_d;
    logic        sdo_q, sdo_d;
    logic        sclk_q;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic [7:0]  last_cmd_q, last_cmd_d;
    logic [31:0] last_addr_q, last_addr_d;
    logic [31:0] last_data_q, last_data_d;

    logic        rise, fall;
    logic        addr_oor;
    logic        ram_we;
    logic [31:0] ram_rdata, rd_word, data_shift;

    assign rise       = spi_sclk & ~sclk_q;
    assign fall       = ~spi_sclk & sclk_q;
    assign data_shift = {data_q[30:0], spi_sdi};

    // The address register is resolved outside the FSM block so the RAM read of the
    // final address bit is available on the same rise that ends ADDR.
    assign addr_d   = (state_q == ST_ADDR && rise && !spi_cs) ? {addr_q[30:0], spi_sdi} : addr_q;
    assign addr_oor = |addr_d[31:MEM_AW+2];
    assign rd_word  = addr_oor ? '0 : ram_rdata;

    spi_target_ram #(.MEM_AW(MEM_AW)) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (addr_d[MEM_AW+1:2]),
        .wdata_i (data_shift),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        sr_d        = sr_q;
        rd_d        = rd_q;
        sdo_d       = sdo_q;
        err_d       = err_q;
        done_d      = 1'b0;
        last_cmd_d  = last_cmd_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        ram_we      = 1'b0;

        if (state_q == ST_IDLE) begin
            if (!spi_cs) begin
                state_d = ST_CMD;
                cnt_d   = '0;
            end
        end else if (spi_cs) begin
            // CS wins over a coincident SCLK rise; only a frame boundary is a clean end.
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (!(state_q == ST_CMD && cnt_q == '0) && state_q != ST_IGNORE) begin
                err_d = 1'b1;
            end
        end else if (rise) begin
            cnt_d = cnt_q + 6'd1;
            unique case (state_q)
                ST_CMD: begin
                    cmd_d = {cmd_q[6:0], spi_sdi};
                    if (cnt_q == CMD_LAST) begin
                        cnt_d = '0;
                        if (cmd_d == OPC_WRITE || cmd_d == OPC_READ) begin
                            state_d = ST_ADDR;
                            rd_d    = (cmd_d == OPC_READ);
                        end else begin
                            state_d = ST_IGNORE;
                            err_d   = 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d = '0;
                        if (addr_oor) err_d = 1'b1;
                        if (!rd_q) begin
                            state_d = ST_WDATA;
                        end else if (DUMMY_CYCLES == 0) begin
                            state_d = ST_RDATA;
                            sr_d    = rd_word;
                            data_d  = rd_word;
                            sdo_d   = 1'b0;
                        end else begin
                            state_d = ST_DUMMY;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (cnt_q == DUMMY_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RDATA;
                        sr_d    = rd_word;
                        data_d  = rd_word;
                        sdo_d   = 1'b0;
                    end
                end
                ST_WDATA: begin
                    data_d = data_shift;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d       = '0;
                        state_d     = ST_CMD;
                        ram_we      = !addr_oor;
                        done_d      = 1'b1;
                        last_cmd_d  = cmd_q;
                        last_addr_d = addr_q;
                        last_data_d = data_shift;
                    end
                end
                ST_RDATA: begin
                    if (cnt_q == DATA_LAST) begin
                        cnt_d       = '0;
                        state_d     = ST_CMD;
                        done_d      = 1'b1;
                        last_cmd_d  = cmd_q;
                        last_addr_d = addr_q;
                        last_data_d = data_q;
                    end
                end
                ST_IGNORE: cnt_d = cnt_q;
                default:   cnt_d = cnt_q;
            endcase
        end else if (fall && state_q == ST_RDATA) begin
            sdo_d = sr_q[31];
            sr_d  = {sr_q[30:0], 1'b0};
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            sr_q        <= '0;
            rd_q        <= 1'b0;
            sdo_q       <= 1'b0;
            sclk_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            last_cmd_q  <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            sr_q        <= sr_d;
            rd_q        <= rd_d;
            sdo_q       <= sdo_d;
            sclk_q      <= spi_sclk;
            err_q       <= err_d;
            done_q      <= done_d;
            last_cmd_q  <= last_cmd_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
        end
    end

    assign spi_sdo    = (state_q == ST_RDATA) & sdo_q;
    assign frame_done = done_q;
    assign last_cmd   = last_cmd_q;
    assign last_addr  = last_addr_q;
    assign last_data  = last_data_q;
    assign err        = err_q;

`ifdef SPI_TARGET_WRCNT_EN
    logic [15:0] wr_count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_count_q <= '0;
        end else if (ram_we && wr_count_q != 16'hFFFF) begin
            wr_count_q <= wr_count_q + 16'd1;
        end
    end

    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_spi_target_mem.sv
// Directed bench for spi_target_mem: SPI frames driven bit by bit, results compared to hand-computed values.
module tb_spi_target_mem;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        spi_sclk;
    logic        spi_sdi;
    logic        spi_cs;
    logic        spi_sdo;
    logic        frame_done;
    logic [7:0]  last_cmd;
    logic [31:0] last_addr;
    logic [31:0] last_data;
    logic        err;
`ifdef SPI_TARGET_WRCNT_EN
    logic [15:0] wr_count;
`endif

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    always #5 clk_i = ~clk_i;

    spi_target_mem #(.MEM_AW(6), .DUMMY_CYCLES(34)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .spi_sclk   (spi_sclk),
        .spi_sdi    (spi_sdi),
        .spi_cs     (spi_cs),
        .spi_sdo    (spi_sdo),
        .frame_done (frame_done),
        .last_cmd   (last_cmd),
        .last_addr  (last_addr),
        .last_data  (last_data),
        .err        (err)
`ifdef SPI_TARGET_WRCNT_EN
        ,
        .wr_count   (wr_count)
`endif
    );

    always @(negedge clk_i) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    // One SCLK period: sdi set while SCLK low, sdo sampled just before the rise.
    task automatic spi_bit(input logic b, output logic o);
        spi_sdi  = b;
        o        = spi_sdo;
        spi_sclk = 1'b1;
        repeat (2) @(negedge clk_i);
        spi_sclk = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic send(input logic [31:0] v, input int n);
        logic o;
        for (int i = n - 1; i >= 0; i--) spi_bit(v[i], o);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic cs_high();
        spi_cs = 1'b1;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic write_frame(input logic [31:0] addr, input logic [31:0] data);
        send(32'h02, 8);
        send(addr, 32);
        send(data, 32);
    endtask

    // Returns the shifted-out word and the number of dummy bits where sdo was not 0.
    task automatic read_frame(input logic [31:0] addr, output logic [31:0] data, output int nz);
        logic o;
        send(32'h0B, 8);
        send(addr, 32);
        nz = 0;
        for (int i = 0; i < 34; i++) begin
            spi_bit(1'b0, o);
            if (o !== 1'b0) nz++;
        end
        data = '0;
        for (int i = 0; i < 32; i++) begin
            spi_bit(1'b0, o);
            data = {data[30:0], o};
        end
    endtask

    task automatic do_reset();
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        spi_sdi  = 1'b0;
        rst_i    = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({frame_done, err, spi_sdo} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got done/err/sdo=%b%b%b, want 000", frame_done, err, spi_sdo);
        end
        checks++;
        if ({last_cmd, last_addr, last_data} !== 72'h0) begin
            errors++;
            $display("FAIL reset_last: got cmd=%h addr=%h data=%h, want all 0", last_cmd, last_addr, last_data);
        end
    endtask

    task automatic test_write();
        done_cnt = 0;
        cs_low();
        write_frame(32'h64, 32'h64);
        cs_high();
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL write_done: got %0d pulses, want 1", done_cnt);
        end
        checks++;
        if (last_cmd !== 8'h02 || last_addr !== 32'h64 || last_data !== 32'h64) begin
            errors++;
            $display("FAIL write_last: got cmd=%h addr=%h data=%h, want 02 00000064 00000064",
                     last_cmd, last_addr, last_data);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL write_err: got %b, want 0", err);
        end
    endtask

    task automatic test_read();
        logic [31:0] d;
        int nz;
        done_cnt = 0;
        cs_low();
        read_frame(32'h64, d, nz);
        cs_high();
        checks++;
        if (d !== 32'h0000_0064) begin
            errors++;
            $display("FAIL read_sdo: got %h, want 00000064", d);
        end
        checks++;
        if (nz !== 0) begin
            errors++;
            $display("FAIL read_dummy_sdo: got %0d non-zero dummy bits, want 0", nz);
        end
        checks++;
        if (last_cmd !== 8'h0B || last_data !== 32'h64 || done_cnt !== 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL read_status: got cmd=%h data=%h done=%0d err=%b, want 0b 00000064 1 0",
                     last_cmd, last_data, done_cnt, err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int nz;
        done_cnt = 0;
        cs_low();
        write_frame(32'h0, 32'hA5A5_5A5A);
        read_frame(32'h0, d, nz);
        cs_high();
        checks++;
        if (d !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL b2b_data: got %h, want a5a55a5a", d);
        end
        checks++;
        if (done_cnt !== 2) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses, want 2", done_cnt);
        end
        checks++;
        if (last_cmd !== 8'h0B || last_addr !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_last: got cmd=%h addr=%h err=%b, want 0b 00000000 0", last_cmd, last_addr, err);
        end
    endtask

    task automatic test_bad_opcode();
        logic o;
        int nz;
        done_cnt = 0;
        nz = 0;
        cs_low();
        send(32'h03, 8);
        for (int i = 0; i < 40; i++) begin
            spi_bit(1'b1, o);
            if (o !== 1'b0) nz++;
        end
        cs_high();
        checks++;
        if (err !== 1'b1 || done_cnt !== 0) begin
            errors++;
            $display("FAIL badop_status: got err=%b done=%0d, want 1 0", err, done_cnt);
        end
        checks++;
        if (nz !== 0) begin
            errors++;
            $display("FAIL badop_sdo: got %0d non-zero bits, want 0", nz);
        end
        done_cnt = 0;
        cs_low();
        write_frame(32'h8, 32'h1234_5678);
        cs_high();
        checks++;
        if (done_cnt !== 1 || last_data !== 32'h1234_5678 || last_addr !== 32'h8) begin
            errors++;
            $display("FAIL badop_recover: got done=%0d addr=%h data=%h, want 1 00000008 12345678",
                     done_cnt, last_addr, last_data);
        end
    endtask

    task automatic test_cs_abort();
        logic [31:0] d;
        int nz;
        do_reset();
        cs_low();
        write_frame(32'h10, 32'h1111_2222);
        cs_high();
        done_cnt = 0;
        cs_low();
        send(32'h02, 8);
        send(32'h10, 32);
        send(32'hFFFF_FFFF, 20);
        cs_high();
        checks++;
        if (err !== 1'b1 || done_cnt !== 0) begin
            errors++;
            $display("FAIL abort_status: got err=%b done=%0d, want 1 0", err, done_cnt);
        end
        cs_low();
        read_frame(32'h10, d, nz);
        cs_high();
        checks++;
        if (d !== 32'h1111_2222) begin
            errors++;
            $display("FAIL abort_word: got %h, want 11112222", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        int nz;
        do_reset();
        cs_low();
        write_frame(32'h1000, 32'hDEAD_BEEF);
        cs_high();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL oor_err: got %b, want 1", err);
        end
        cs_low();
        read_frame(32'h1000, d, nz);
        cs_high();
        checks++;
        if (d !== 32'h0 || last_addr !== 32'h1000) begin
            errors++;
            $display("FAIL oor_read: got data=%h addr=%h, want 00000000 00001000", d, last_addr);
        end
        cs_low();
        read_frame(32'h0, d, nz);
        cs_high();
        checks++;
        if (d !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL oor_alias: got word0=%h, want a5a55a5a", d);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_bad_opcode();
        test_cs_abort();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
